// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB pipeline stage.
// Skid-buffer state encoding, control-bundle bit positions and default widths.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_t;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_WE       = 2;
  localparam int CTRL_RE       = 3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CTRL_W = 4;
  localparam int DEF_DEST_W = 5;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry skid buffer with flush: 1-cycle latency; inReady is registered
// and drops only when both the main and skid entries are occupied.
module pipe_skid_buffer
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  skidState_t       state;
  skidState_t       nextState;
  logic [WIDTH-1:0] mainQ;
  logic [WIDTH-1:0] skidQ;
  logic             readyQ;

  logic accept;
  logic transfer;
  logic loadMain;
  logic mainFromSkid;
  logic loadSkid;

  assign accept   = inValid && readyQ;
  assign transfer = (state != EMPTY) && outReady;

  always_comb begin
    nextState    = state;
    loadMain     = 1'b0;
    mainFromSkid = 1'b0;
    loadSkid     = 1'b0;
    if (Flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState = ONE;
            loadMain  = 1'b1;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            loadMain = 1'b1;
          end else if (accept) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (transfer) begin
            nextState = EMPTY;
          end
        end
        TWO: begin
          // Skid entry slides into main on the same edge the main entry leaves.
          if (transfer) begin
            nextState    = ONE;
            loadMain     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= EMPTY;
      readyQ <= 1'b0;
      mainQ  <= '0;
      skidQ  <= '0;
    end else begin
      state  <= nextState;
      readyQ <= (nextState != TWO);
      if (loadMain) begin
        mainQ <= mainFromSkid ? skidQ : inData;
      end
      if (loadSkid) begin
        skidQ <= inData;
      end
    end
  end

  assign inReady  = readyQ;
  assign outValid = (state != EMPTY);
  assign outData  = mainQ;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB stage: 1-cycle accept-to-valid; payload held under backpressure, skid or single register.
// Control is gated with out_valid so bubbles never write; stall cycles counted with saturation.
module mem_wb_pipe_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [DEST_W-1:0]        dest_in,
  input  logic                     Flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [DEST_W-1:0]        dest_out,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int PAY_W = NUM_CH*DATA_W + CTRL_W + DEST_W;

  logic [PAY_W-1:0]  inPayload;
  logic [PAY_W-1:0]  outPayload;
  logic [CTRL_W-1:0] ctrlHeld;
  logic [CNT_W-1:0]  stallQ;

  assign inPayload = {data_in, ctrl_in, dest_in};

  generate
    if (SKID != 0) begin : gSkid
      pipe_skid_buffer #(
        .WIDTH(PAY_W)
      ) uSkid (
        .Clock   (Clock),
        .Reset   (Reset),
        .Flush   (Flush),
        .inValid (in_valid),
        .inReady (in_ready),
        .inData  (inPayload),
        .outValid(out_valid),
        .outReady(out_ready),
        .outData (outPayload)
      );
    end else begin : gReg
      logic             liveQ;
      logic             validQ;
      logic [PAY_W-1:0] payQ;

      // liveQ keeps in_ready low during Reset even though the path is combinational.
      assign in_ready   = liveQ && (!validQ || out_ready);
      assign out_valid  = validQ;
      assign outPayload = payQ;

      always_ff @(posedge Clock) begin
        if (Reset) begin
          liveQ  <= 1'b0;
          validQ <= 1'b0;
          payQ   <= '0;
        end else begin
          liveQ <= 1'b1;
          if (Flush) begin
            validQ <= 1'b0;
          end else if (in_valid && in_ready) begin
            validQ <= 1'b1;
            payQ   <= inPayload;
          end else if (validQ && out_ready) begin
            validQ <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign {data_out, ctrlHeld, dest_out} = outPayload;
  assign ctrl_out = ctrlHeld & {CTRL_W{out_valid}};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stallQ <= '0;
    end else if (out_valid && !out_ready && (stallQ != {CNT_W{1'b1}})) begin
      stallQ <= stallQ + CNT_W'(1);
    end
  end

  assign stall_cycles = stallQ;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench: skid (A), single-register (B) and 4-bit-counter (C) instances.
module tb_mem_wb_pipe_stage;
  import mem_wb_pkg::*;

  logic Clock;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  logic         aInValid, aInReady, aFlush, aOutValid, aOutReady;
  logic [127:0] aDataIn, aDataOut;
  logic [3:0]   aCtrlIn, aCtrlOut;
  logic [4:0]   aDestIn, aDestOut;
  logic [15:0]  aStall;

  logic         bInValid, bInReady, bFlush, bOutValid, bOutReady;
  logic [127:0] bDataIn, bDataOut;
  logic [3:0]   bCtrlIn, bCtrlOut;
  logic [4:0]   bDestIn, bDestOut;
  logic [15:0]  bStall;

  logic         cInValid, cInReady, cFlush, cOutValid, cOutReady;
  logic [127:0] cDataIn, cDataOut;
  logic [3:0]   cCtrlIn, cCtrlOut;
  logic [4:0]   cDestIn, cDestOut;
  logic [3:0]   cStall;

  mem_wb_pipe_stage #(.SKID(1)) dutA (
    .Clock(Clock), .Reset(Reset), .in_valid(aInValid), .in_ready(aInReady),
    .data_in(aDataIn), .ctrl_in(aCtrlIn), .dest_in(aDestIn), .Flush(aFlush),
    .out_valid(aOutValid), .out_ready(aOutReady), .data_out(aDataOut),
    .ctrl_out(aCtrlOut), .dest_out(aDestOut), .stall_cycles(aStall)
  );

  mem_wb_pipe_stage #(.SKID(0)) dutB (
    .Clock(Clock), .Reset(Reset), .in_valid(bInValid), .in_ready(bInReady),
    .data_in(bDataIn), .ctrl_in(bCtrlIn), .dest_in(bDestIn), .Flush(bFlush),
    .out_valid(bOutValid), .out_ready(bOutReady), .data_out(bDataOut),
    .ctrl_out(bCtrlOut), .dest_out(bDestOut), .stall_cycles(bStall)
  );

  mem_wb_pipe_stage #(.SKID(1), .CNT_W(4)) dutC (
    .Clock(Clock), .Reset(Reset), .in_valid(cInValid), .in_ready(cInReady),
    .data_in(cDataIn), .ctrl_in(cCtrlIn), .dest_in(cDestIn), .Flush(cFlush),
    .out_valid(cOutValid), .out_ready(cOutReady), .data_out(cDataOut),
    .ctrl_out(cCtrlOut), .dest_out(cDestOut), .stall_cycles(cStall)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [127:0] mkData(logic [31:0] v);
    return {v ^ 32'h3000, v ^ 32'h2000, v ^ 32'h1000, v};
  endfunction

  task automatic checkEq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    aInValid = 1'b1; aFlush = 1'b0; aOutReady = 1'b0; aDataIn = '0; aCtrlIn = 4'b1111; aDestIn = '0;
    bInValid = 1'b1; bFlush = 1'b0; bOutReady = 1'b0; bDataIn = '0; bCtrlIn = 4'b1111; bDestIn = '0;
    cInValid = 1'b1; cFlush = 1'b0; cOutReady = 1'b0; cDataIn = '0; cCtrlIn = 4'b1111; cDestIn = '0;
    Reset = 1'b1;

    // Reset held two cycles with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      tick;
      checkEq("rst_a_in_ready", 64'(aInReady), 64'(0));
      checkEq("rst_b_in_ready", 64'(bInReady), 64'(0));
      checkEq("rst_a_out_valid", 64'(aOutValid), 64'(0));
      checkEq("rst_a_ctrl_out", 64'(aCtrlOut), 64'(0));
    end
    checkEq("rst_a_data_out", 64'(aDataOut[63:0]), 64'(0));
    checkEq("rst_a_stall", 64'(aStall), 64'(0));
    Reset = 1'b0; aInValid = 1'b0; bInValid = 1'b0; cInValid = 1'b0;
    tick;
    checkEq("rel_a_in_ready", 64'(aInReady), 64'(1));
    checkEq("rel_b_in_ready", 64'(bInReady), 64'(1));
    checkEq("rel_c_in_ready", 64'(cInReady), 64'(1));
    checkEq("rel_a_out_valid", 64'(aOutValid), 64'(0));

    // Streaming with out_ready high
    aOutReady = 1'b1; aInValid = 1'b1;
    aDataIn = mkData(32'h11); aCtrlIn = 4'b0001; aDestIn = 5'd1;
    tick;
    checkEq("str_valid0", 64'(aOutValid), 64'(1));
    checkEq("str_ch0_11", 64'(aDataOut[31:0]), 64'h11);
    checkEq("str_ch3_11", 64'(aDataOut[127:96]), 64'h3011);
    checkEq("str_ctrl_11", 64'(aCtrlOut), 64'h1);
    checkEq("str_dest_11", 64'(aDestOut), 64'd1);
    aDataIn = mkData(32'h22); aCtrlIn = 4'b0101; aDestIn = 5'd2;
    tick;
    checkEq("str_ch0_22", 64'(aDataOut[31:0]), 64'h22);
    checkEq("str_ctrl_22", 64'(aCtrlOut), 64'h5);
    aDataIn = mkData(32'h33); aDestIn = 5'd3;
    tick;
    checkEq("str_ch0_33", 64'(aDataOut[31:0]), 64'h33);
    checkEq("str_dest_33", 64'(aDestOut), 64'd3);
    aInValid = 1'b0;
    tick;
    checkEq("str_drain_valid", 64'(aOutValid), 64'(0));
    checkEq("str_drain_ctrl", 64'(aCtrlOut), 64'(0));
    checkEq("str_stall", 64'(aStall), 64'(0));

    // Backpressure: fill main and skid, third entry held upstream
    aOutReady = 1'b0; aInValid = 1'b1; aDataIn = mkData(32'hA0); aCtrlIn = 4'b0011;
    tick;
    checkEq("bp_rdy_one", 64'(aInReady), 64'(1));
    aDataIn = mkData(32'hA1);
    tick;
    checkEq("bp_rdy_drop", 64'(aInReady), 64'(0));
    aDataIn = mkData(32'hA2);
    tick;
    tick;
    checkEq("bp_stall3", 64'(aStall), 64'd3);
    checkEq("bp_hold_a0", 64'(aDataOut[31:0]), 64'hA0);
    checkEq("bp_hold_ctrl", 64'(aCtrlOut), 64'h3);
    aOutReady = 1'b1;
    tick;
    checkEq("bp_out_a1", 64'(aDataOut[31:0]), 64'hA1);
    checkEq("bp_rdy_back", 64'(aInReady), 64'(1));
    tick;
    checkEq("bp_out_a2", 64'(aDataOut[31:0]), 64'hA2);
    aInValid = 1'b0;
    tick;
    checkEq("bp_empty", 64'(aOutValid), 64'(0));
    checkEq("bp_stall_end", 64'(aStall), 64'd3);

    // Flush while in TWO with all control bits asserted on the input
    aOutReady = 1'b0; aInValid = 1'b1; aDataIn = mkData(32'hB0); aCtrlIn = 4'b0001;
    tick;
    aDataIn = mkData(32'hB1);
    tick;
    checkEq("fl_two_rdy", 64'(aInReady), 64'(0));
    aFlush = 1'b1; aDataIn = mkData(32'hFF); aCtrlIn = 4'b1111;
    tick;
    checkEq("fl_valid", 64'(aOutValid), 64'(0));
    checkEq("fl_ctrl", 64'(aCtrlOut), 64'(0));
    checkEq("fl_rdy", 64'(aInReady), 64'(1));
    checkEq("fl_stall", 64'(aStall), 64'd5);
    aFlush = 1'b0; aInValid = 1'b0; aOutReady = 1'b1;
    tick;
    checkEq("fl_no_ghost", 64'(aOutValid), 64'(0));

    // Flush discards an accept landing on the same edge
    aInValid = 1'b1; aFlush = 1'b1; aDataIn = mkData(32'hEE); aCtrlIn = 4'b1111;
    tick;
    aFlush = 1'b0; aInValid = 1'b0;
    checkEq("fl_acc_valid", 64'(aOutValid), 64'(0));
    checkEq("fl_acc_ctrl", 64'(aCtrlOut), 64'(0));
    tick;
    checkEq("fl_acc_later", 64'(aOutValid), 64'(0));

    // Single-register mode: back-to-back without bubbles
    bOutReady = 1'b1; bInValid = 1'b1; bDataIn = mkData(32'hC0); bCtrlIn = 4'b0001;
    tick;
    checkEq("b_valid_c0", 64'(bOutValid), 64'(1));
    checkEq("b_ch0_c0", 64'(bDataOut[31:0]), 64'hC0);
    bDataIn = mkData(32'hC1); bCtrlIn = 4'b0100;
    #1;
    checkEq("b_rdy_comb", 64'(bInReady), 64'(1));
    tick;
    checkEq("b_valid_c1", 64'(bOutValid), 64'(1));
    checkEq("b_ch0_c1", 64'(bDataOut[31:0]), 64'hC1);
    checkEq("b_ctrl_c1", 64'(bCtrlOut), 64'h4);
    bOutReady = 1'b0; bDataIn = mkData(32'hC2);
    #1;
    checkEq("b_rdy_low", 64'(bInReady), 64'(0));
    tick;
    checkEq("b_hold_c1", 64'(bDataOut[31:0]), 64'hC1);
    checkEq("b_stall1", 64'(bStall), 64'd1);
    bOutReady = 1'b1;
    #1;
    checkEq("b_rdy_release", 64'(bInReady), 64'(1));
    tick;
    checkEq("b_ch0_c2", 64'(bDataOut[31:0]), 64'hC2);
    bInValid = 1'b0;
    tick;
    checkEq("b_empty", 64'(bOutValid), 64'(0));
    checkEq("b_ctrl_bubble", 64'(bCtrlOut), 64'(0));

    // Counter saturation with a 4-bit counter
    cOutReady = 1'b0; cInValid = 1'b1; cDataIn = mkData(32'hD0); cCtrlIn = 4'b0001;
    tick;
    cInValid = 1'b0;
    repeat (20) tick;
    checkEq("c_sat15", 64'(cStall), 64'd15);
    checkEq("c_still_valid", 64'(cOutValid), 64'(1));
    cOutReady = 1'b1;
    tick;
    tick;
    checkEq("c_sat_hold", 64'(cStall), 64'd15);
    checkEq("c_drained", 64'(cOutValid), 64'(0));

    // Reset in the middle of operation
    aOutReady = 1'b0; aInValid = 1'b1; aDataIn = mkData(32'hF0); aCtrlIn = 4'b0001;
    tick;
    Reset = 1'b1; aFlush = 1'b1; aOutReady = 1'b1;
    tick;
    checkEq("mr_valid", 64'(aOutValid), 64'(0));
    checkEq("mr_rdy", 64'(aInReady), 64'(0));
    checkEq("mr_stall", 64'(aStall), 64'(0));
    checkEq("mr_data", 64'(aDataOut[31:0]), 64'(0));
    checkEq("mr_c_stall", 64'(cStall), 64'(0));
    Reset = 1'b0; aFlush = 1'b0; aInValid = 1'b0;
    tick;
    checkEq("mr_rdy_back", 64'(aInReady), 64'(1));
    checkEq("mr_still_empty", 64'(aOutValid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
